// File: rtl/ram_wr_seq.sv
// Write-side sequencer for the dual-port RAM: clears the array after reset, then
// turns framed valid/ready stream words into registered RAM writes from a base address.
module ram_wr_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  init_done,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [CW-1:0]         clr_cnt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         len_eff;
  logic [CW-1:0]         count_inc;

  assign count_inc = count + CW'(1);

  // Handshake and status decode purely from the state register
  assign s_ready = (state == WRITE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      base_q    <= '0;
      len_eff   <= '0;
      we        <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_done <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        CLEAR: begin
          if (clr_cnt == CW'(DEPTH)) begin
            we        <= 1'b0;
            init_done <= 1'b1;
            state     <= IDLE;
          end else begin
            we      <= 1'b1;
            wr_addr <= clr_cnt[ADDR_WIDTH-1:0];
            wr_data <= '0;
            clr_cnt <= clr_cnt + CW'(1);
          end
        end
        IDLE: begin
          we <= 1'b0;
          if (start) begin
            base_q  <= base_addr;
            // len of zero encodes a full-depth frame
            len_eff <= (len == '0) ? CW'(DEPTH) : {1'b0, len};
            count   <= '0;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (s_valid) begin
            we      <= 1'b1;
            wr_addr <= base_q + count[ADDR_WIDTH-1:0];
            wr_data <= s_data;
            count   <= count_inc;
            if (count_inc == len_eff) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            we <= 1'b0;
          end
        end
        DONE: begin
          we    <= 1'b0;
          state <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wr_seq.sv
// Directed bench for ram_wr_seq with ADDR_WIDTH=4: clear, framed writes, wrap,
// bubbles, ignored start, full-depth frame and mid-frame reset.
module tb_ram_wr_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] len;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          init_done;
  logic          done;
  logic [AW:0]   count;

  int total;
  int bad;

  typedef struct {
    logic          st;
    logic [AW-1:0] b;
    logic [AW-1:0] l;
    logic          v;
    logic [DW-1:0] d;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_done;
    logic          e_ready;
    logic [AW:0]   e_count;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];

  ram_wr_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .init_done(init_done),
    .done(done), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic st, input int b, input int l, input logic v,
                               input int d, input logic e_we, input int e_addr,
                               input int e_data, input logic e_done, input logic e_ready,
                               input int e_count, input logic e_busy);
    vec_t r;
    r.st = st; r.b = AW'(b); r.l = AW'(l); r.v = v; r.d = DW'(d);
    r.e_we = e_we; r.e_addr = AW'(e_addr); r.e_data = DW'(e_data);
    r.e_done = e_done; r.e_ready = e_ready; r.e_count = (AW+1)'(e_count);
    r.e_busy = e_busy;
    return r;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; s_valid = 1'b0; s_data = '0;

    // Basic frame base=0 len=4
    vecs.push_back(mkv(1, 0, 4, 0, 'h00, 0, 15, 'h00, 0, 1, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'hA0, 1, 0, 'hA0, 0, 1, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'hA1, 1, 1, 'hA1, 0, 1, 2, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'hA2, 1, 2, 'hA2, 0, 1, 3, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'hA3, 1, 3, 'hA3, 1, 0, 4, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 'h00, 0, 3, 'hA3, 0, 0, 4, 0));
    // Wrap frame base=14 len=4
    vecs.push_back(mkv(1, 14, 4, 0, 'h00, 0, 3, 'hA3, 0, 1, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'h11, 1, 14, 'h11, 0, 1, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'h22, 1, 15, 'h22, 0, 1, 2, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'h33, 1, 0, 'h33, 0, 1, 3, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'h44, 1, 1, 'h44, 1, 0, 4, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 'h00, 0, 1, 'h44, 0, 0, 4, 0));
    // Bubbles base=5 len=3, valid 1,0,0,1,0,1; start in WRITE and DONE ignored
    vecs.push_back(mkv(1, 5, 3, 0, 'h00, 0, 1, 'h44, 0, 1, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'h51, 1, 5, 'h51, 0, 1, 1, 1));
    vecs.push_back(mkv(1, 9, 1, 0, 'hEE, 0, 5, 'h51, 0, 1, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 'hEE, 0, 5, 'h51, 0, 1, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'h52, 1, 6, 'h52, 0, 1, 2, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 'hEE, 0, 6, 'h52, 0, 1, 2, 1));
    vecs.push_back(mkv(0, 0, 0, 1, 'h53, 1, 7, 'h53, 1, 0, 3, 1));
    vecs.push_back(mkv(1, 2, 2, 1, 'h77, 0, 7, 'h53, 0, 0, 3, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 'h00, 0, 7, 'h53, 0, 0, 3, 0));

    // Reset values
    tick(); tick();
    chk("rst_we", int'(we), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(s_ready), 0);

    // Array clear
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("clr_we", int'(we), 1);
      chk("clr_addr", int'(wr_addr), i);
      chk("clr_data", int'(wr_data), 0);
      chk("clr_init_done", int'(init_done), 0);
      chk("clr_busy", int'(busy), 1);
    end
    tick();
    chk("clr_end_we", int'(we), 0);
    chk("clr_end_init_done", int'(init_done), 1);
    chk("clr_end_busy", int'(busy), 0);
    chk("clr_end_ready", int'(s_ready), 0);

    // Table-driven frames
    foreach (vecs[i]) begin
      start = vecs[i].st; base_addr = vecs[i].b; len = vecs[i].l;
      s_valid = vecs[i].v; s_data = vecs[i].d;
      tick();
      chk($sformatf("v%0d_we", i), int'(we), int'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i), int'(wr_addr), int'(vecs[i].e_addr));
      chk($sformatf("v%0d_data", i), int'(wr_data), int'(vecs[i].e_data));
      chk($sformatf("v%0d_done", i), int'(done), int'(vecs[i].e_done));
      chk($sformatf("v%0d_ready", i), int'(s_ready), int'(vecs[i].e_ready));
      chk($sformatf("v%0d_count", i), int'(count), int'(vecs[i].e_count));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
    end

    // Full-depth frame (len=0) from base=3
    start = 1'b1; base_addr = 4'd3; len = 4'd0; s_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("f16_ready", int'(s_ready), 1);
    chk("f16_count0", int'(count), 0);
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = DW'(8'h80 + i);
      tick();
      chk("f16_we", int'(we), 1);
      chk("f16_addr", int'(wr_addr), (3 + i) % 16);
      chk("f16_data", int'(wr_data), 8'h80 + i);
      chk("f16_count", int'(count), i + 1);
      chk("f16_done", int'(done), (i == 15) ? 1 : 0);
    end
    s_valid = 1'b0;
    tick();
    chk("f16_end_done", int'(done), 0);
    chk("f16_end_count", int'(count), 16);
    chk("f16_end_ready", int'(s_ready), 0);

    // Reset after 2 of 4 words
    start = 1'b1; base_addr = 4'd0; len = 4'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = DW'(8'hC0 + i);
      tick();
    end
    chk("mid_count", int'(count), 2);
    rst = 1'b1;
    tick();
    chk("mr_we", int'(we), 0);
    chk("mr_count", int'(count), 0);
    chk("mr_init_done", int'(init_done), 0);
    chk("mr_busy", int'(busy), 1);
    chk("mr_ready", int'(s_ready), 0);
    rst = 1'b0; s_valid = 1'b0;
    tick();
    chk("mr_clr_we", int'(we), 1);
    chk("mr_clr_addr", int'(wr_addr), 0);
    chk("mr_clr_data", int'(wr_data), 0);
    chk("mr_clr_init_done", int'(init_done), 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("mr_clr_addr_i", int'(wr_addr), i);
    end
    tick();
    chk("mr_clr_end_we", int'(we), 0);
    chk("mr_clr_end_init", int'(init_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_wr_seq.md
Name: ram_wr_seq

Overview:
Write-side sequencer that feeds the write port of the team's dual-port RAM (asyncram). It clears the whole array after reset. It then accepts framed stream data over a valid/ready handshake and issues one registered RAM write per accepted word, at incrementing addresses from a programmable base with wrap-around. It runs in the write-clock domain; its we/wr_addr/wr_data outputs connect directly to the RAM's we/wr_addr/data_in.

Parameters:
DATA_WIDTH, 8, width of stream data and RAM word
ADDR_WIDTH, 8, RAM address width; depth = 2**ADDR_WIDTH

Ports:
clk  input  1  write-side clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  frame request; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first write address of frame, latched on start
len  input  ADDR_WIDTH  frame length in words, latched on start; 0 means 2**ADDR_WIDTH
s_valid  input  1  upstream data valid
s_data  input  DATA_WIDTH  upstream data
s_ready  output  1  sequencer can accept a word this cycle
we  output  1  RAM write enable
wr_addr  output  ADDR_WIDTH  RAM write address
wr_data  output  DATA_WIDTH  RAM write data
busy  output  1  high in CLEAR, WRITE and DONE
init_done  output  1  sticky high once the array clear completes
done  output  1  one-cycle pulse at end of frame
count  output  ADDR_WIDTH+1  words accepted in current/last frame

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high; rst overrides everything, including mid-frame and mid-clear.
- Reset values: state=CLEAR, we=0, wr_addr=0, wr_data=0, init_done=0, done=0, count=0, busy=1, s_ready=0.
- we, wr_addr, wr_data, done, init_done and count are registered. s_ready is decoded from the state register only: high iff state==WRITE. It never depends combinationally on s_valid.
- FSM states: CLEAR, IDLE, WRITE, DONE.
- CLEAR: starts in the first cycle after rst deasserts.
  - Each cycle: we=1, wr_data=0, wr_addr steps 0,1,...,2**ADDR_WIDTH-1.
  - The clear takes exactly 2**ADDR_WIDTH write cycles.
  - On the edge after the last clear write: we=0, init_done=1, state goes to IDLE.
- IDLE: we=0, busy=0.
  - start=1 latches base_addr and len, clears count to 0, and moves to WRITE on the next edge.
  - start is ignored in every state except IDLE.
- WRITE: a word is accepted on an edge where s_valid && s_ready.
  - On the following cycle: we=1, wr_addr=(base+count_before) mod 2**ADDR_WIDTH, wr_data=s_data. Write latency from accept is 1 cycle.
  - count increments on each accept.
  - On a cycle with no accept, we=0 next cycle; wr_addr and wr_data hold their values.
  - On the edge where count becomes the effective length (len, or 2**ADDR_WIDTH when len=0), state goes to DONE, so s_ready drops in the next cycle.
- Address wrap: the address is computed modulo 2**ADDR_WIDTH and silently wraps, e.g. 255 -> 0 for ADDR_WIDTH=8.
- DONE: lasts one cycle.
  - The final word's write (we=1) appears in this cycle.
  - done=1 for exactly this cycle, then state returns to IDLE.
  - count holds its final value until the next start.
- A write and done in the same cycle are legal and expected.
- s_data is not sampled when s_valid=0. Upstream may toggle s_valid freely (bubbles).

Test Plan:
- Reset/clear, ADDR_WIDTH=4: release rst -> 16 consecutive cycles with we=1, wr_addr 0..15, wr_data=0; init_done rises the cycle after addr 15; busy=0 afterwards.
- Basic frame: start, base=0, len=4, s_valid held high with data A0,A1,A2,A3 -> writes at addresses 0..3 with those data, each 1 cycle after accept; done pulses once; count=4; s_ready low after the 4th accept.
- Wrap, ADDR_WIDTH=4: base=14, len=4, data 11,22,33,44 -> addresses 14,15,0,1; done=1 once.
- Bubbles: len=3 with s_valid pattern 1,0,0,1,0,1 -> exactly 3 writes; we=0 in gap cycles; wr_addr held through gaps.
- len=0, ADDR_WIDTH=4: 16 words accepted -> addresses base..base+15 mod 16; count=16.
- Protocol/reset: start pulsed during WRITE -> ignored, frame unaffected. rst asserted after 2 of 4 words -> next cycle re-enters CLEAR (we=1, addr 0), init_done=0, count=0.
